// File: rtl/shk_axi_arbiter_if.sv
// rtl/shk_axi_arbiter_if.sv - requester, shk_to_axi master-port and status signals of shk_axi_arbiter
interface shk_axi_arbiter_if #(
  parameter int N_REQ = 4,
  parameter int AW    = 32,
  parameter int DW    = 32
);
  localparam int GW = (N_REQ > 1) ? $clog2(N_REQ) : 1;

  logic [N_REQ-1:0]    req_vld;
  logic [N_REQ-1:0]    req_rdy;
  logic [N_REQ-1:0]    req_wr;
  logic [N_REQ*AW-1:0] req_addr;
  logic [N_REQ*DW-1:0] req_wdata;
  logic [N_REQ-1:0]    rsp_vld;
  logic                rsp_err;
  logic [DW-1:0]       rsp_rdata;
  logic                m_txn_init;
  logic                m_txn_wr;
  logic [AW-1:0]       m_txn_addr;
  logic [DW-1:0]       m_txn_wdata;
  logic                m_txn_done;
  logic                m_txn_error;
  logic [DW-1:0]       m_txn_rdata;
  logic                busy;
  logic [GW-1:0]       grant_id;
  logic                timeout_stky;

  modport master (
    input  req_vld, req_wr, req_addr, req_wdata,
    input  m_txn_done, m_txn_error, m_txn_rdata,
    output req_rdy, rsp_vld, rsp_err, rsp_rdata,
    output m_txn_init, m_txn_wr, m_txn_addr, m_txn_wdata,
    output busy, grant_id, timeout_stky
  );

  modport slave (
    output req_vld, req_wr, req_addr, req_wdata,
    output m_txn_done, m_txn_error, m_txn_rdata,
    input  req_rdy, rsp_vld, rsp_err, rsp_rdata,
    input  m_txn_init, m_txn_wr, m_txn_addr, m_txn_wdata,
    input  busy, grant_id, timeout_stky
  );
endinterface

// File: rtl/shk_axi_arbiter.sv
// rtl/shk_axi_arbiter.sv - round-robin arbiter sharing one shk_to_axi master between N requesters
// Optional WAIT watchdog enabled by defining SHK_ARB_TIMEOUT_EN.
module shk_axi_arbiter #(
  parameter int N_REQ       = 4,
  parameter int AW          = 32,
  parameter int DW          = 32,
  parameter int TIMEOUT_CYC = 1024
) (
  input  logic               aclk,
  input  logic               areset,
  shk_axi_arbiter_if.master  bus
);
  localparam int GW = (N_REQ > 1) ? $clog2(N_REQ) : 1;

  typedef enum logic [1:0] {S_IDLE, S_LAUNCH, S_WAIT, S_RESP} state_t;

  state_t        state, state_nxt;
  logic [GW-1:0] rr_ptr;
  logic [GW-1:0] grant_q;
  logic [GW-1:0] win_idx;
  logic          win_found;
  logic          pay_wr;
  logic [AW-1:0] pay_addr;
  logic [DW-1:0] pay_wdata;
  logic          rsp_err_q;
  logic [DW-1:0] rsp_rdata_q;
  logic          to_hit;

  // First requester at or above rr_ptr, wrapping at N_REQ-1.
  always_comb begin
    int j;
    j         = 0;
    win_found = 1'b0;
    win_idx   = '0;
    for (int k = 0; k < N_REQ; k++) begin
      j = (int'(rr_ptr) + k) % N_REQ;
      if (!win_found && bus.req_vld[j]) begin
        win_found = 1'b1;
        win_idx   = GW'(j);
      end
    end
  end

  always_ff @(posedge aclk) begin
    if (areset) state <= S_IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE:   if (win_found) state_nxt = S_LAUNCH;
      S_LAUNCH: state_nxt = S_WAIT;
      S_WAIT:   if (bus.m_txn_done || to_hit) state_nxt = S_RESP;
      S_RESP:   state_nxt = S_IDLE;
      default:  state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge aclk) begin
    if (areset) begin
      rr_ptr      <= '0;
      grant_q     <= '0;
      pay_wr      <= 1'b0;
      pay_addr    <= '0;
      pay_wdata   <= '0;
      rsp_err_q   <= 1'b0;
      rsp_rdata_q <= '0;
    end else begin
      case (state)
        S_IDLE: if (win_found) begin
          grant_q   <= win_idx;
          pay_wr    <= bus.req_wr[win_idx];
          pay_addr  <= bus.req_addr[win_idx*AW +: AW];
          pay_wdata <= bus.req_wdata[win_idx*DW +: DW];
        end
        // DONE in the watchdog limit cycle still counts as a normal completion.
        S_WAIT: if (bus.m_txn_done) begin
          rsp_err_q   <= bus.m_txn_error;
          rsp_rdata_q <= pay_wr ? '0 : bus.m_txn_rdata;
        end else if (to_hit) begin
          rsp_err_q   <= 1'b1;
          rsp_rdata_q <= '0;
        end
        S_RESP: rr_ptr <= (int'(grant_q) == N_REQ - 1) ? '0 : grant_q + 1'b1;
        default: ;
      endcase
    end
  end

  always_comb begin
    bus.req_rdy     = '0;
    bus.rsp_vld     = '0;
    bus.rsp_err     = 1'b0;
    bus.rsp_rdata   = '0;
    bus.m_txn_init  = 1'b0;
    bus.m_txn_wr    = 1'b0;
    bus.m_txn_addr  = '0;
    bus.m_txn_wdata = '0;
    case (state)
      S_IDLE: if (win_found && !areset) bus.req_rdy[win_idx] = 1'b1;
      S_LAUNCH: begin
        bus.m_txn_init  = 1'b1;
        bus.m_txn_wr    = pay_wr;
        bus.m_txn_addr  = pay_addr;
        bus.m_txn_wdata = pay_wdata;
      end
      S_WAIT: begin
        bus.m_txn_wr    = pay_wr;
        bus.m_txn_addr  = pay_addr;
        bus.m_txn_wdata = pay_wdata;
      end
      S_RESP: begin
        bus.rsp_vld[grant_q] = 1'b1;
        bus.rsp_err          = rsp_err_q;
        bus.rsp_rdata        = rsp_rdata_q;
      end
      default: ;
    endcase
  end

  assign bus.busy     = (state != S_IDLE);
  assign bus.grant_id = grant_q;

`ifdef SHK_ARB_TIMEOUT_EN
  localparam int CW = $clog2(TIMEOUT_CYC) + 1;

  logic [CW-1:0] wait_cnt;
  logic          stky_q;

  always_ff @(posedge aclk) begin
    if (areset) begin
      wait_cnt <= '0;
      stky_q   <= 1'b0;
    end else begin
      if (state != S_WAIT) wait_cnt <= '0;
      else if (!to_hit)    wait_cnt <= wait_cnt + 1'b1;
      if (to_hit && !bus.m_txn_done) stky_q <= 1'b1;
    end
  end

  assign to_hit           = (state == S_WAIT) && (wait_cnt == CW'(TIMEOUT_CYC - 1));
  assign bus.timeout_stky = stky_q;
`else
  assign to_hit           = 1'b0;
  assign bus.timeout_stky = 1'b0;
`endif
endmodule

// File: tb/tb_shk_axi_arbiter.sv
// tb/tb_shk_axi_arbiter.sv - directed self-checking bench for shk_axi_arbiter
module tb_shk_axi_arbiter;
  localparam int N  = 4;
  localparam int AW = 32;
  localparam int DW = 32;
`ifdef SHK_ARB_TIMEOUT_EN
  localparam int TO = 16;
`else
  localparam int TO = 1024;
`endif

  logic aclk = 1'b0;
  logic areset;
  int   n_chk  = 0;
  int   n_fail = 0;

  shk_axi_arbiter_if #(.N_REQ(N), .AW(AW), .DW(DW)) bus();

  shk_axi_arbiter #(.N_REQ(N), .AW(AW), .DW(DW), .TIMEOUT_CYC(TO)) dut (
    .aclk   (aclk),
    .areset (areset),
    .bus    (bus)
  );

  always #5 aclk = ~aclk;

  task automatic tick;
    @(posedge aclk);
    #1;
  endtask

  task automatic clear_inputs;
    bus.req_vld     = '0;
    bus.req_wr      = '0;
    bus.req_addr    = '0;
    bus.req_wdata   = '0;
    bus.m_txn_done  = 1'b0;
    bus.m_txn_error = 1'b0;
    bus.m_txn_rdata = '0;
  endtask

  task automatic do_reset;
    areset = 1'b1;
    repeat (2) tick();
    areset = 1'b0;
  endtask

  task automatic set_req(input int i, input logic wr, input logic [31:0] a, input logic [31:0] d);
    bus.req_wr[i]             = wr;
    bus.req_addr[i*AW +: AW]  = a;
    bus.req_wdata[i*DW +: DW] = d;
  endtask

  task automatic test_reset;
    clear_inputs();
    bus.req_vld = 4'hF;
    areset = 1'b1;
    for (int c = 0; c < 5; c++) begin
      tick();
      n_chk++; if (bus.req_rdy !== 4'b0000) begin n_fail++; $display("FAIL rst_req_rdy: got %b expected 0000", bus.req_rdy); end
      n_chk++; if (bus.busy !== 1'b0) begin n_fail++; $display("FAIL rst_busy: got %b expected 0", bus.busy); end
      n_chk++; if (bus.rsp_vld !== 4'b0000) begin n_fail++; $display("FAIL rst_rsp_vld: got %b expected 0000", bus.rsp_vld); end
      n_chk++; if (bus.m_txn_init !== 1'b0) begin n_fail++; $display("FAIL rst_init: got %b expected 0", bus.m_txn_init); end
      n_chk++; if (bus.grant_id !== 2'd0) begin n_fail++; $display("FAIL rst_grant_id: got %0d expected 0", bus.grant_id); end
      n_chk++; if (bus.m_txn_addr !== 32'h0) begin n_fail++; $display("FAIL rst_addr: got %h expected 0", bus.m_txn_addr); end
      n_chk++; if (bus.timeout_stky !== 1'b0) begin n_fail++; $display("FAIL rst_stky: got %b expected 0", bus.timeout_stky); end
    end
    bus.req_vld = '0;
    areset = 1'b0;
  endtask

  task automatic test_single_write;
    clear_inputs();
    set_req(2, 1'b1, 32'h40, 32'hA5A5_0001);
    bus.req_vld = 4'b0100;
    #1;
    n_chk++; if (bus.req_rdy !== 4'b0100) begin n_fail++; $display("FAIL wr_req_rdy: got %b expected 0100", bus.req_rdy); end
    tick();
    bus.req_vld = '0;
    n_chk++; if (bus.m_txn_init !== 1'b1) begin n_fail++; $display("FAIL wr_init: got %b expected 1", bus.m_txn_init); end
    n_chk++; if (bus.m_txn_addr !== 32'h40) begin n_fail++; $display("FAIL wr_addr: got %h expected 00000040", bus.m_txn_addr); end
    n_chk++; if (bus.m_txn_wdata !== 32'hA5A5_0001) begin n_fail++; $display("FAIL wr_wdata: got %h expected a5a50001", bus.m_txn_wdata); end
    n_chk++; if (bus.m_txn_wr !== 1'b1) begin n_fail++; $display("FAIL wr_dir: got %b expected 1", bus.m_txn_wr); end
    n_chk++; if (bus.grant_id !== 2'd2) begin n_fail++; $display("FAIL wr_grant_id: got %0d expected 2", bus.grant_id); end
    n_chk++; if (bus.req_rdy !== 4'b0000) begin n_fail++; $display("FAIL wr_rdy_pulse: got %b expected 0000", bus.req_rdy); end
    for (int c = 1; c <= 5; c++) begin
      tick();
      n_chk++; if (bus.m_txn_init !== 1'b0) begin n_fail++; $display("FAIL wr_init_once: got %b expected 0 at INIT+%0d", bus.m_txn_init, c); end
      n_chk++; if (bus.m_txn_addr !== 32'h40) begin n_fail++; $display("FAIL wr_addr_hold: got %h expected 00000040", bus.m_txn_addr); end
      n_chk++; if (bus.rsp_vld !== 4'b0000) begin n_fail++; $display("FAIL wr_early_rsp: got %b expected 0000", bus.rsp_vld); end
    end
    tick();
    bus.m_txn_done  = 1'b1;
    bus.m_txn_rdata = 32'hFFFF_FFFF;
    tick();
    bus.m_txn_done  = 1'b0;
    n_chk++; if (bus.rsp_vld !== 4'b0100) begin n_fail++; $display("FAIL wr_rsp_vld: got %b expected 0100", bus.rsp_vld); end
    n_chk++; if (bus.rsp_err !== 1'b0) begin n_fail++; $display("FAIL wr_rsp_err: got %b expected 0", bus.rsp_err); end
    n_chk++; if (bus.rsp_rdata !== 32'h0) begin n_fail++; $display("FAIL wr_rdata_zero: got %h expected 0", bus.rsp_rdata); end
    tick();
    n_chk++; if (bus.rsp_vld !== 4'b0000) begin n_fail++; $display("FAIL wr_rsp_pulse: got %b expected 0000", bus.rsp_vld); end
    n_chk++; if (bus.busy !== 1'b0) begin n_fail++; $display("FAIL wr_idle_busy: got %b expected 0", bus.busy); end
  endtask

  task automatic test_round_robin;
    int         exp;
    logic [3:0] oh;
    clear_inputs();
    do_reset();
    for (int i = 0; i < N; i++) set_req(i, 1'b0, 32'h100 + 32'(4 * i), 32'h0);
    bus.req_vld = 4'hF;
    for (int n = 0; n < 5; n++) begin
      exp = n % N;
      oh  = 4'(1 << exp);
      #1;
      n_chk++; if (bus.req_rdy !== oh) begin n_fail++; $display("FAIL rr_req_rdy[%0d]: got %b expected %b", n, bus.req_rdy, oh); end
      tick();
      n_chk++; if (bus.grant_id !== 2'(exp)) begin n_fail++; $display("FAIL rr_grant_id[%0d]: got %0d expected %0d", n, bus.grant_id, exp); end
      n_chk++; if (bus.m_txn_addr !== 32'h100 + 32'(4 * exp)) begin n_fail++; $display("FAIL rr_addr[%0d]: got %h expected %h", n, bus.m_txn_addr, 32'h100 + 32'(4 * exp)); end
      // first pass: a DONE landing in the LAUNCH cycle must be ignored
      if (n == 0) begin
        bus.m_txn_done  = 1'b1;
        bus.m_txn_rdata = 32'hBAD;
      end
      tick();
      bus.m_txn_done = 1'b0;
      n_chk++; if (bus.rsp_vld !== 4'b0000 || bus.busy !== 1'b1) begin n_fail++; $display("FAIL rr_wait[%0d]: got rsp_vld=%b busy=%b expected 0000/1", n, bus.rsp_vld, bus.busy); end
      bus.m_txn_done  = 1'b1;
      bus.m_txn_rdata = 32'h1000 + 32'(exp);
      tick();
      bus.m_txn_done  = 1'b0;
      n_chk++; if (bus.rsp_vld !== oh) begin n_fail++; $display("FAIL rr_rsp_vld[%0d]: got %b expected %b", n, bus.rsp_vld, oh); end
      n_chk++; if (bus.rsp_rdata !== 32'h1000 + 32'(exp)) begin n_fail++; $display("FAIL rr_rdata[%0d]: got %h expected %h", n, bus.rsp_rdata, 32'h1000 + 32'(exp)); end
      n_chk++; if (bus.req_rdy !== 4'b0000) begin n_fail++; $display("FAIL rr_rdy_busy[%0d]: got %b expected 0000", n, bus.req_rdy); end
      tick();
    end
    bus.req_vld = '0;
  endtask

  task automatic test_read_error;
    clear_inputs();
    set_req(1, 1'b0, 32'h10, 32'h1234);
    bus.req_vld = 4'b0010;
    #1;
    n_chk++; if (bus.req_rdy !== 4'b0010) begin n_fail++; $display("FAIL rd_req_rdy: got %b expected 0010", bus.req_rdy); end
    tick();
    bus.req_vld = '0;
    n_chk++; if (bus.m_txn_wr !== 1'b0 || bus.m_txn_addr !== 32'h10) begin n_fail++; $display("FAIL rd_payload: got wr=%b addr=%h expected 0/00000010", bus.m_txn_wr, bus.m_txn_addr); end
    tick();
    bus.m_txn_done  = 1'b1;
    bus.m_txn_error = 1'b1;
    bus.m_txn_rdata = 32'hDEAD;
    tick();
    clear_inputs();
    n_chk++; if (bus.rsp_vld !== 4'b0010) begin n_fail++; $display("FAIL rd_rsp_vld: got %b expected 0010", bus.rsp_vld); end
    n_chk++; if (bus.rsp_err !== 1'b1) begin n_fail++; $display("FAIL rd_rsp_err: got %b expected 1", bus.rsp_err); end
    n_chk++; if (bus.rsp_rdata !== 32'hDEAD) begin n_fail++; $display("FAIL rd_rdata: got %h expected 0000dead", bus.rsp_rdata); end
    tick();
    n_chk++; if (bus.rsp_vld !== 4'b0000 || bus.rsp_err !== 1'b0) begin n_fail++; $display("FAIL rd_rsp_pulse: got vld=%b err=%b expected 0000/0", bus.rsp_vld, bus.rsp_err); end
  endtask

  task automatic test_reset_mid_wait;
    clear_inputs();
    set_req(3, 1'b1, 32'h300, 32'h33);
    set_req(0, 1'b1, 32'h0, 32'h44);
    bus.req_vld = 4'b1001;
    #1;
    n_chk++; if (bus.req_rdy !== 4'b1000) begin n_fail++; $display("FAIL mid_rr_skip: got %b expected 1000", bus.req_rdy); end
    tick();
    bus.req_vld = '0;
    n_chk++; if (bus.m_txn_init !== 1'b1) begin n_fail++; $display("FAIL mid_init: got %b expected 1", bus.m_txn_init); end
    repeat (3) tick();
    areset = 1'b1;
    repeat (2) tick();
    areset = 1'b0;
    n_chk++; if (bus.busy !== 1'b0 || bus.rsp_vld !== 4'b0000) begin n_fail++; $display("FAIL mid_abandon: got busy=%b rsp_vld=%b expected 0/0000", bus.busy, bus.rsp_vld); end
    bus.m_txn_done = 1'b1;
    tick();
    bus.m_txn_done = 1'b0;
    n_chk++; if (bus.rsp_vld !== 4'b0000 || bus.busy !== 1'b0) begin n_fail++; $display("FAIL mid_late_done: got rsp_vld=%b busy=%b expected 0000/0", bus.rsp_vld, bus.busy); end
    bus.req_vld = 4'b1001;
    #1;
    n_chk++; if (bus.req_rdy !== 4'b0001) begin n_fail++; $display("FAIL mid_rr_restart: got %b expected 0001", bus.req_rdy); end
    tick();
    bus.req_vld = '0;
    tick();
    bus.m_txn_done = 1'b1;
    tick();
    bus.m_txn_done = 1'b0;
    n_chk++; if (bus.rsp_vld !== 4'b0001) begin n_fail++; $display("FAIL mid_next_rsp: got %b expected 0001", bus.rsp_vld); end
    tick();
  endtask

  task automatic test_wait_watchdog;
    clear_inputs();
    do_reset();
    set_req(2, 1'b0, 32'h80, 32'h0);
    bus.req_vld = 4'b0100;
    tick();
    bus.req_vld = '0;
    n_chk++; if (bus.m_txn_init !== 1'b1) begin n_fail++; $display("FAIL wd_init: got %b expected 1", bus.m_txn_init); end
`ifdef SHK_ARB_TIMEOUT_EN
    for (int j = 1; j <= 16; j++) begin
      tick();
      n_chk++; if (bus.rsp_vld !== 4'b0000 || bus.busy !== 1'b1) begin n_fail++; $display("FAIL wd_wait[%0d]: got rsp_vld=%b busy=%b expected 0000/1", j, bus.rsp_vld, bus.busy); end
    end
    tick();
    n_chk++; if (bus.rsp_vld !== 4'b0100 || bus.rsp_err !== 1'b1) begin n_fail++; $display("FAIL wd_timeout_rsp: got vld=%b err=%b expected 0100/1", bus.rsp_vld, bus.rsp_err); end
    n_chk++; if (bus.rsp_rdata !== 32'h0) begin n_fail++; $display("FAIL wd_timeout_rdata: got %h expected 0", bus.rsp_rdata); end
    n_chk++; if (bus.timeout_stky !== 1'b1) begin n_fail++; $display("FAIL wd_stky_set: got %b expected 1", bus.timeout_stky); end
    tick();
    n_chk++; if (bus.timeout_stky !== 1'b1 || bus.busy !== 1'b0) begin n_fail++; $display("FAIL wd_stky_hold: got stky=%b busy=%b expected 1/0", bus.timeout_stky, bus.busy); end
    do_reset();
    n_chk++; if (bus.timeout_stky !== 1'b0) begin n_fail++; $display("FAIL wd_stky_clear: got %b expected 0", bus.timeout_stky); end
`else
    for (int j = 1; j <= 40; j++) begin
      tick();
      n_chk++; if (bus.rsp_vld !== 4'b0000 || bus.busy !== 1'b1 || bus.timeout_stky !== 1'b0) begin n_fail++; $display("FAIL wd_no_timeout[%0d]: got rsp_vld=%b busy=%b stky=%b expected 0000/1/0", j, bus.rsp_vld, bus.busy, bus.timeout_stky); end
    end
    bus.m_txn_done  = 1'b1;
    bus.m_txn_rdata = 32'h5A;
    tick();
    bus.m_txn_done  = 1'b0;
    n_chk++; if (bus.rsp_vld !== 4'b0100 || bus.rsp_err !== 1'b0) begin n_fail++; $display("FAIL wd_late_done: got vld=%b err=%b expected 0100/0", bus.rsp_vld, bus.rsp_err); end
    n_chk++; if (bus.rsp_rdata !== 32'h5A) begin n_fail++; $display("FAIL wd_late_rdata: got %h expected 0000005a", bus.rsp_rdata); end
    tick();
`endif
  endtask

  initial begin
    clear_inputs();
    areset = 1'b1;
    test_reset();
    test_single_write();
    test_round_robin();
    test_read_error();
    test_reset_mid_wait();
    test_wait_watchdog();
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
